// File: rtl/ram_scan_pkg.sv
// Shared definitions for the RAM display scanner: state encoding, default
// timing constants and the counter-width helper.
package ram_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_FINISH = 3'd4
  } scan_state_e;

  localparam int unsigned DEFAULT_READ_LAT    = 2;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 25_000_000;

  // Bits needed to count 0..n inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned HOLD_CNT_W = cnt_width(DEFAULT_HOLD_CYCLES);

endpackage

// File: rtl/ram_display_scanner_if.sv
// Read port between the scanner and one port of the dual-port bram.
interface ram_display_scanner_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] q;

  modport master (output rd_addr, input  q);
  modport slave  (input  rd_addr, output q);
endinterface

// File: rtl/ram_display_scanner.sv
// Walks a bram address range and shows each word on four hex digits,
// holding each word for a programmable dwell. Strictly read-only.
module ram_display_scanner
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned READ_LAT    = DEFAULT_READ_LAT,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  ram_display_scanner_if.master ram,
  output logic [3:0]            h3,
  output logic [3:0]            h2,
  output logic [3:0]            h1,
  output logic [3:0]            h0,
  output logic [ADDR_W-1:0]     cur_addr,
  output logic                  busy,
  output logic                  sample_valid,
  output logic                  done
);

  localparam int unsigned WAIT_W = cnt_width(READ_LAT);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  scan_state_e       state_q, state_n;
  logic [ADDR_W-1:0] cur_q, cur_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [ADDR_W-1:0] last_q, last_n;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_n;
  logic [WAIT_W-1:0] wait_q, wait_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic              latch;
  logic              sample_valid_n;
  logic              done_n;
  logic              busy_n;

  assign ram.rd_addr = rd_addr_q;

  // NOTE: every signal gets its default before the case so that no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_n        = state_q;
    cur_n          = cur_q;
    base_n         = base_q;
    last_n         = last_q;
    rd_addr_n      = rd_addr_q;
    wait_n         = wait_q;
    hold_n         = hold_q;
    latch          = 1'b0;
    sample_valid_n = 1'b0;
    done_n         = 1'b0;

    if (stop) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_n  = base_addr;
            last_n  = last_addr;
            cur_n   = base_addr;
            state_n = S_ISSUE;
          end
        end
        S_ISSUE: begin
          rd_addr_n = cur_q;
          wait_n    = '0;
          state_n   = S_WAIT;
        end
        S_WAIT: begin
          // >= rather than == so a corrupted count still terminates.
          if (wait_q >= WAIT_LAST) begin
            latch          = 1'b1;
            sample_valid_n = 1'b1;
            hold_n         = '0;
            state_n        = S_HOLD;
          end else begin
            wait_n = wait_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (step || hold_q >= HOLD_LAST) begin
            if (cur_q != last_q) begin
              cur_n   = cur_q + 1'b1;
              state_n = S_ISSUE;
            end else if (loop_en) begin
              cur_n   = base_q;
              state_n = S_ISSUE;
            end else begin
              state_n = S_FINISH;
            end
          end else begin
            hold_n = hold_q + 1'b1;
          end
        end
        S_FINISH: begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // busy stays up through the done pulse so it falls one cycle after done.
    busy_n = (state_n != S_IDLE) || done_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      base_q       <= '0;
      last_q       <= '0;
      rd_addr_q    <= '0;
      wait_q       <= '0;
      hold_q       <= '0;
      h3           <= '0;
      h2           <= '0;
      h1           <= '0;
      h0           <= '0;
      cur_addr     <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_n;
      cur_q        <= cur_n;
      base_q       <= base_n;
      last_q       <= last_n;
      rd_addr_q    <= rd_addr_n;
      wait_q       <= wait_n;
      hold_q       <= hold_n;
      busy         <= busy_n;
      sample_valid <= sample_valid_n;
      done         <= done_n;
      if (latch) begin
        h3       <= ram.q[15:12];
        h2       <= ram.q[11:8];
        h1       <= ram.q[7:4];
        h0       <= ram.q[3:0];
        cur_addr <= cur_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_display_scanner.sv
// Scoreboard bench for ram_display_scanner: expected words and done pulses are
// queued with their due cycle when a scan is launched and matched on output.
module tb_ram_display_scanner;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int READ_LAT = 2;
  localparam int HOLD     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              step = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        h3, h2, h1, h0;
  logic [ADDR_W-1:0] cur_addr;
  logic              busy, sample_valid, done;

  ram_display_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

  ram_display_scanner #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step),
    .loop_en(loop_en), .base_addr(base_addr), .last_addr(last_addr),
    .ram(ram_bus), .h3(h3), .h2(h2), .h1(h1), .h0(h0),
    .cur_addr(cur_addr), .busy(busy), .sample_valid(sample_valid), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read port behind the registered rd_addr.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'(16'hA000 + i);
  always @(posedge clk) ram_bus.q <= mem[ram_bus.rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int at;
  } sample_t;

  sample_t exp_q[$];
  int      done_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      t0 = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    sample_t s;
    int      d;
    if (sample_valid === 1'b1) begin
      check("sv_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        check("sv_cycle", cyc, s.at);
        check("digits", 32'({h3, h2, h1, h0}), 32'(16'(16'hA000 + s.addr)));
        check("cur_addr", 32'(cur_addr), s.addr);
        check("rd_addr", 32'(ram_bus.rd_addr), s.addr);
      end
    end
    if (done === 1'b1) begin
      check("done_expected", 32'(done_q.size() != 0), 32'd1);
      if (done_q.size() != 0) begin
        d = done_q.pop_front();
        check("done_cycle", cyc, d);
      end
    end
  end

  task automatic push_word(input int addr, input int at);
    sample_t s;
    s.addr = addr % (1 << ADDR_W);
    s.at   = at;
    exp_q.push_back(s);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic begin_scan(input int base, input int last, input logic lp);
    @(negedge clk);
    base_addr = ADDR_W'(base);
    last_addr = ADDR_W'(last);
    loop_en   = lp;
    start     = 1'b1;
    t0        = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    @(negedge clk);
    check("rd_addr_first", 32'(ram_bus.rd_addr), base);
  endtask

  task automatic finish_scan(input int fall_at);
    int k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("busy_idle", 32'(busy), 32'd0);
    check("busy_fall_cycle", cyc, fall_at);
    check("sb_words_left", exp_q.size(), 32'd0);
    check("sb_done_left", done_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_rd_addr", 32'(ram_bus.rd_addr), 32'd0);
    check("rst_digits", 32'({h3, h2, h1, h0}), 32'd0);
    check("rst_flags", 32'({busy, sample_valid, done}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan 0..3.
    begin_scan(0, 3, 1'b0);
    for (int k = 0; k < 4; k++) push_word(k, t0 + 3 + 7 * k);
    done_q.push_back(t0 + 29);
    finish_scan(t0 + 30);

    // Range wrapping through the top of the address space.
    begin_scan(1022, 1, 1'b0);
    for (int k = 0; k < 4; k++) push_word(1022 + k, t0 + 3 + 7 * k);
    done_q.push_back(t0 + 29);
    finish_scan(t0 + 30);
    check("wrap_last_digits", 32'({h3, h2, h1, h0}), 32'h0000_A001);

    // Loop mode, loop_en dropped during the third dwell.
    begin_scan(5, 6, 1'b1);
    push_word(5, t0 + 3);
    push_word(6, t0 + 10);
    push_word(5, t0 + 17);
    push_word(6, t0 + 24);
    done_q.push_back(t0 + 29);
    wait_cyc(t0 + 18);
    loop_en = 1'b0;
    finish_scan(t0 + 30);

    // step on the first HOLD cycle shortens the period to 4.
    begin_scan(10, 11, 1'b0);
    push_word(10, t0 + 3);
    push_word(11, t0 + 7);
    done_q.push_back(t0 + 12);
    wait_cyc(t0 + 3);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    check("step_rd_addr", 32'(ram_bus.rd_addr), 32'd11);
    finish_scan(t0 + 13);

    // stop together with step during WAIT aborts without sample or done.
    begin_scan(20, 22, 1'b0);
    push_word(20, t0 + 3);
    wait_cyc(t0 + 8);
    stop = 1'b1;
    step = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    step = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_digits", 32'({h3, h2, h1, h0}), 32'h0000_A014);
    check("stop_cur_addr", 32'(cur_addr), 32'd20);
    wait_cyc(t0 + 20);
    check("stop_words_left", exp_q.size(), 32'd0);
    check("stop_busy_later", 32'(busy), 32'd0);

    // start and stop together in IDLE stays idle.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    check("start_stop_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-HOLD, then a clean single-word restart.
    begin_scan(30, 31, 1'b0);
    push_word(30, t0 + 3);
    wait_cyc(t0 + 5);
    #2 reset = 1'b0;
    #1;
    check("arst_rd_addr", 32'(ram_bus.rd_addr), 32'd0);
    check("arst_cur_addr", 32'(cur_addr), 32'd0);
    check("arst_digits", 32'({h3, h2, h1, h0}), 32'd0);
    check("arst_flags", 32'({busy, sample_valid, done}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin_scan(40, 40, 1'b0);
    push_word(40, t0 + 3);
    done_q.push_back(t0 + 8);
    finish_scan(t0 + 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
